// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and defaults for the two-port RAM arbiter.
// Holds the FSM state enum, port count and default hold/gap lengths.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        GAP
    } state_t;

    localparam int NPORT       = 2;
    localparam int RD_HOLD_DEF = 20;
    localparam int WR_HOLD_DEF = 20;
    localparam int GAP_CYC_DEF = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester and RAM-side bundle of the arbiter.
// slave = arbiter view, master = requesters/RAM view.
interface ram_arbiter_if;

    logic        req0;
    logic        we0;
    logic        byte0;
    logic [21:0] addr0;
    logic [15:0] wdata0;
    logic        ack0;
    logic [15:0] rdata0;

    logic        req1;
    logic        we1;
    logic        byte1;
    logic [21:0] addr1;
    logic [15:0] wdata1;
    logic        ack1;
    logic [15:0] rdata1;

    logic        ram_read;
    logic        ram_write;
    logic        ram_byte;
    logic [21:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic        init;
    logic        busy;

    modport slave (
        input  req0, we0, byte0, addr0, wdata0,
        input  req1, we1, byte1, addr1, wdata1,
        input  ram_rdata, init,
        output ack0, rdata0, ack1, rdata1,
        output ram_read, ram_write, ram_byte,
        output ram_addr, ram_wdata, busy
    );

    modport master (
        output req0, we0, byte0, addr0, wdata0,
        output req1, we1, byte1, addr1, wdata1,
        output ram_rdata, init,
        input  ack0, rdata0, ack1, rdata1,
        input  ram_read, ram_write, ram_byte,
        input  ram_addr, ram_wdata, busy
    );

endinterface

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational two-way grant selector.
// The pointer names the preferred port; a lone request always wins.
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic [NPORT-1:0] i_req,
    input  logic             i_ptr,
    output logic             o_idx,
    output logic             o_valid
);

    // Preferred port first, otherwise the other one.
    always_comb begin
        o_valid = |i_req;
        o_idx   = 1'b0;
        if (i_req[i_ptr])
            o_idx = i_ptr;
        else if (i_req[~i_ptr])
            o_idx = ~i_ptr;
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port PSRAM arbiter (DCJ11 CPU / Apple II bus).
// Define RAM_ARB_RR_EN for round-robin ties; default is port 0 priority.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int RD_HOLD = RD_HOLD_DEF,
    parameter int WR_HOLD = WR_HOLD_DEF,
    parameter int GAP_CYC = GAP_CYC_DEF
) (
    input  logic          mclk,
    input  logic          rst,
    ram_arbiter_if.slave  bus
);

    localparam int MAXC  = max3(RD_HOLD, WR_HOLD, GAP_CYC);
    localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_owner;
    logic               r_ack0;
    logic               r_ack1;
    logic [15:0]        r_rdata0;
    logic [15:0]        r_rdata1;
    logic               r_ram_byte;
    logic [21:0]        r_ram_addr;
    logic [15:0]        r_ram_wdata;

    logic [NPORT-1:0]   w_req;
    logic               w_ptr;
    logic               w_idx;
    logic               w_valid;
    logic               w_grant;
    logic               w_we;
    logic               w_rd_last;
    logic               w_wr_last;
    logic               w_gap_last;
    logic               w_ram_read;
    logic               w_ram_write;
    logic               w_busy;

    assign w_req      = {bus.req1, bus.req0};
    assign w_grant    = (r_state == IDLE) && bus.init && w_valid;
    assign w_we       = w_idx ? bus.we1 : bus.we0;
    assign w_rd_last  = (r_state == RD)
                      && (r_cnt == CNT_W'(RD_HOLD - 1));
    assign w_wr_last  = (r_state == WR)
                      && (r_cnt == CNT_W'(WR_HOLD - 1));
    assign w_gap_last = (r_state == GAP)
                      && (r_cnt == CNT_W'(GAP_CYC - 1));

    ram_arb_pick u_pick (
        .i_req   (w_req),
        .i_ptr   (w_ptr),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

`ifdef RAM_ARB_RR_EN
    logic r_rr;
    assign w_ptr = r_rr;

    // Prefer the port not served by the latest grant.
    always_ff @(posedge mclk) begin
        if (rst)
            r_rr <= 1'b0;
        else if (w_grant)
            r_rr <= ~w_idx;
    end
`else
    assign w_ptr = 1'b0;
`endif

    // State register.
    always_ff @(posedge mclk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (w_grant) w_next = w_we ? WR : RD;
            RD:   if (w_rd_last) w_next = GAP;
            WR:   if (w_wr_last) w_next = GAP;
            GAP:  if (w_gap_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Strobes and busy decode straight from the state.
    always_comb begin
        w_ram_read  = 1'b0;
        w_ram_write = 1'b0;
        w_busy      = (r_state != IDLE);
        unique case (r_state)
            RD:      w_ram_read  = 1'b1;
            WR:      w_ram_write = 1'b1;
            default: ;
        endcase
    end

    // Shared hold/gap counter, cleared on every state change.
    always_ff @(posedge mclk) begin
        if (rst)
            r_cnt <= '0;
        else if (w_next != r_state)
            r_cnt <= '0;
        else if (r_state != IDLE)
            r_cnt <= r_cnt + 1'b1;
    end

    // Capture the winner's request on the grant edge.
    always_ff @(posedge mclk) begin
        if (rst) begin
            r_owner     <= 1'b0;
            r_ram_byte  <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else if (w_grant) begin
            r_owner     <= w_idx;
            r_ram_byte  <= w_idx ? bus.byte1  : bus.byte0;
            r_ram_addr  <= w_idx ? bus.addr1  : bus.addr0;
            r_ram_wdata <= w_idx ? bus.wdata1 : bus.wdata0;
        end
    end

    // Completion pulse and read-data capture for the owner only.
    always_ff @(posedge mclk) begin
        if (rst) begin
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_ack0 <= (w_rd_last || w_wr_last) && !r_owner;
            r_ack1 <= (w_rd_last || w_wr_last) &&  r_owner;
            if (w_rd_last && !r_owner)
                r_rdata0 <= bus.ram_rdata;
            if (w_rd_last && r_owner)
                r_rdata1 <= bus.ram_rdata;
        end
    end

    assign bus.ram_read  = w_ram_read;
    assign bus.ram_write = w_ram_write;
    assign bus.busy      = w_busy;
    assign bus.ram_byte  = r_ram_byte;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_wdata = r_ram_wdata;
    assign bus.ack0      = r_ack0;
    assign bus.ack1      = r_ack1;
    assign bus.rdata0    = r_rdata0;
    assign bus.rdata1    = r_rdata1;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and random checks of ram_arbiter against
// a timeline model of grants, strobe windows, acks and read data.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    localparam int RH = RD_HOLD_DEF;
    localparam int WH = WR_HOLD_DEF;
    localparam int GC = GAP_CYC_DEF;

    logic mclk = 1'b0;
    logic rst;
    always #5 mclk = ~mclk;

    ram_arbiter_if bus();

    ram_arbiter dut (
        .mclk (mclk),
        .rst  (rst),
        .bus  (bus)
    );

    logic        q_req   [2];
    logic        q_we    [2];
    logic        q_byte  [2];
    logic [21:0] q_addr  [2];
    logic [15:0] q_wdata [2];
    logic [15:0] q_rdata;
    logic        q_init;

    assign bus.req0      = q_req[0];
    assign bus.we0       = q_we[0];
    assign bus.byte0     = q_byte[0];
    assign bus.addr0     = q_addr[0];
    assign bus.wdata0    = q_wdata[0];
    assign bus.req1      = q_req[1];
    assign bus.we1       = q_we[1];
    assign bus.byte1     = q_byte[1];
    assign bus.addr1     = q_addr[1];
    assign bus.wdata1    = q_wdata[1];
    assign bus.ram_rdata = q_rdata;
    assign bus.init      = q_init;

    int n_vec = 0;
    int n_bad = 0;
    int k     = 0;

    // Model: one access = grant edge g, hold h, then GC gap cycles.
    bit          m_act;
    bit          m_own;
    bit          m_we;
    int          m_g;
    int          m_h;
    int          m_next_ok;
    logic [21:0] m_addr;
    logic        m_byte;
    logic [15:0] m_wdata;
    logic [15:0] m_rd [2];
    bit          m_pref;
    bit          m_ack [2];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0d got=%h exp=%h", tag, k, got, exp);
        end
    endtask

    task automatic step();
        logic        s_rst, s_init;
        logic        s_req [2];
        logic        s_we  [2];
        logic        s_byte[2];
        logic [21:0] s_addr[2];
        logic [15:0] s_wd  [2];
        logic [15:0] s_rdata;
        bit          w;
        bit          e_rd, e_wr, e_busy;
        s_rst   = rst;
        s_init  = q_init;
        s_rdata = q_rdata;
        for (int p = 0; p < 2; p++) begin
            s_req[p]  = q_req[p];
            s_we[p]   = q_we[p];
            s_byte[p] = q_byte[p];
            s_addr[p] = q_addr[p];
            s_wd[p]   = q_wdata[p];
        end
        @(posedge mclk);
        #1;
        m_ack[0] = 1'b0;
        m_ack[1] = 1'b0;
        if (s_rst) begin
            m_act     = 1'b0;
            m_addr    = '0;
            m_byte    = 1'b0;
            m_wdata   = '0;
            m_rd[0]   = '0;
            m_rd[1]   = '0;
            m_pref    = 1'b0;
            m_next_ok = k + 1;
        end else begin
            if (m_act && k == m_g + m_h) begin
                m_ack[m_own] = 1'b1;
                if (!m_we) m_rd[m_own] = s_rdata;
            end
            if (k >= m_next_ok && s_init && (s_req[0] || s_req[1])) begin
`ifdef RAM_ARB_RR_EN
                if (s_req[0] && s_req[1]) w = m_pref;
                else w = s_req[1];
                m_pref = !w;
`else
                w = !s_req[0];
`endif
                m_act     = 1'b1;
                m_own     = w;
                m_we      = s_we[w];
                m_g       = k;
                m_h       = s_we[w] ? WH : RH;
                m_next_ok = k + m_h + GC + 1;
                m_addr    = s_addr[w];
                m_byte    = s_byte[w];
                m_wdata   = s_wd[w];
            end
        end
        e_rd   = m_act && !m_we && k >= m_g && k < m_g + m_h;
        e_wr   = m_act &&  m_we && k >= m_g && k < m_g + m_h;
        e_busy = m_act && k >= m_g && k < m_g + m_h + GC;
        chk("ram_read",  32'(bus.ram_read),  32'(e_rd));
        chk("ram_write", 32'(bus.ram_write), 32'(e_wr));
        chk("rw_excl",   32'(bus.ram_read & bus.ram_write), 32'd0);
        chk("busy",      32'(bus.busy),      32'(e_busy));
        chk("ack0",      32'(bus.ack0),      32'(m_ack[0]));
        chk("ack1",      32'(bus.ack1),      32'(m_ack[1]));
        chk("rdata0",    32'(bus.rdata0),    32'(m_rd[0]));
        chk("rdata1",    32'(bus.rdata1),    32'(m_rd[1]));
        chk("ram_addr",  32'(bus.ram_addr),  32'(m_addr));
        chk("ram_byte",  32'(bus.ram_byte),  32'(m_byte));
        chk("ram_wdata", 32'(bus.ram_wdata), 32'(m_wdata));
        k++;
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (bus.busy && i < 200) begin
            step();
            i++;
        end
        chk("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    // Steps until ack on port p; counts steps and strobe-high cycles.
    task automatic wait_ack(input int p, output int n,
                            output int nrd, output int nwr);
        bit got;
        got = 1'b0;
        n   = 0;
        nrd = 0;
        nwr = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            step();
            n++;
            nrd += int'(bus.ram_read);
            nwr += int'(bus.ram_write);
            if ((p == 0) ? bus.ack0 : bus.ack1) got = 1'b1;
        end
        chk("ack_timeout", 32'(got), 32'd1);
    endtask

    task automatic clear_reqs();
        for (int p = 0; p < 2; p++) begin
            q_req[p]   = 1'b0;
            q_we[p]    = 1'b0;
            q_byte[p]  = 1'b0;
            q_addr[p]  = '0;
            q_wdata[p] = '0;
        end
    endtask

    initial begin
        int n, nrd, nwr, cnt, gap;
        int seq[$];
        bit ok;

        clear_reqs();
        q_rdata = '0;
        q_init  = 1'b0;
        rst     = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();

        // Single read from port 0.
        q_init     = 1'b1;
        q_rdata    = 16'h1234;
        q_req[0]   = 1'b1;
        q_addr[0]  = 22'h000100;
        wait_ack(0, n, nrd, nwr);
        q_req[0] = 1'b0;
        chk("rd_latency", 32'(n), 32'(RH + 1));
        chk("rd_hold", 32'(nrd), 32'(RH));
        chk("rd_data", 32'(bus.rdata0), 32'h1234);
        wait_idle();

        // Byte write from port 1 at the top address.
        q_req[1]   = 1'b1;
        q_we[1]    = 1'b1;
        q_byte[1]  = 1'b1;
        q_addr[1]  = 22'h3FFFFF;
        q_wdata[1] = 16'h00AB;
        ok  = 1'b1;
        n   = 0;
        nwr = 0;
        for (int i = 0; i < 200 && !bus.ack1; i++) begin
            step();
            n++;
            if (bus.ram_write) begin
                nwr++;
                if (!bus.ram_byte || bus.ram_addr != 22'h3FFFFF ||
                    bus.ram_wdata != 16'h00AB)
                    ok = 1'b0;
            end
        end
        q_req[1] = 1'b0;
        chk("wr_latency", 32'(n), 32'(WH + 1));
        chk("wr_hold", 32'(nwr), 32'(WH));
        chk("wr_stable", 32'(ok), 32'd1);
        gap = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!bus.busy) break;
            gap++;
        end
        chk("wr_gap", 32'(gap), 32'(GC));
        clear_reqs();

        // Contention: both ports hold reads.
        wait_idle();
        q_req[0]  = 1'b1;
        q_req[1]  = 1'b1;
        q_addr[0] = 22'h000010;
        q_addr[1] = 22'h000020;
        seq.delete();
        for (int i = 0; i < 400 && seq.size() < 4; i++) begin
            q_rdata = 16'($urandom);
            step();
            if (bus.ack0) seq.push_back(0);
            if (bus.ack1) seq.push_back(1);
        end
        clear_reqs();
        chk("cont_count", 32'(seq.size() >= 4), 32'd1);
        if (seq.size() >= 4) begin
`ifdef RAM_ARB_RR_EN
            chk("cont_g0", 32'(seq[0]), 32'd0);
            chk("cont_g1", 32'(seq[1]), 32'd1);
            chk("cont_g2", 32'(seq[2]), 32'd0);
            chk("cont_g3", 32'(seq[3]), 32'd1);
`else
            chk("cont_g0", 32'(seq[0]), 32'd0);
            chk("cont_g1", 32'(seq[1]), 32'd0);
            chk("cont_g2", 32'(seq[2]), 32'd0);
`endif
        end

        // No grant while init is low.
        wait_idle();
        q_init   = 1'b0;
        q_req[0] = 1'b1;
        cnt      = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            cnt += int'(bus.ram_read) + int'(bus.ram_write)
                 + int'(bus.ack0) + int'(bus.ack1);
        end
        chk("init0_quiet", 32'(cnt), 32'd0);
        q_init = 1'b1;
        step();
        chk("init_start", 32'(bus.ram_read), 32'd1);
        wait_ack(0, n, nrd, nwr);
        q_req[0] = 1'b0;

        // Reset in the middle of a write.
        wait_idle();
        q_req[1]   = 1'b1;
        q_we[1]    = 1'b1;
        q_addr[1]  = 22'h0ABCDE;
        q_wdata[1] = 16'h5A5A;
        for (int i = 0; i < 10; i++) step();
        chk("pre_rst_wr", 32'(bus.ram_write), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        q_req[1] = 1'b0;
        chk("rst_wr", 32'(bus.ram_write), 32'd0);
        chk("rst_ack1", 32'(bus.ack1), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_addr", 32'(bus.ram_addr), 32'd0);
        step();
        clear_reqs();

        // Back-to-back reads on port 0.
        wait_idle();
        q_req[0]  = 1'b1;
        q_addr[0] = 22'h001234;
        wait_ack(0, n, nrd, nwr);
        n = 0;
        for (int i = 0; i < 50 && !bus.ram_read; i++) begin
            step();
            n++;
        end
        chk("b2b_gap", 32'(n), 32'(GC + 1));
        wait_ack(0, n, nrd, nwr);
        q_req[0] = 1'b0;

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 149) == 0) q_init = ~q_init;
            if (!q_init && $urandom_range(0, 29) == 0) q_init = 1'b1;
            q_rdata = 16'($urandom);
            for (int p = 0; p < 2; p++) begin
                if ((p == 0) ? bus.ack0 : bus.ack1) begin
                    if ($urandom_range(0, 1) == 0) q_req[p] = 1'b0;
                end else if (!q_req[p]) begin
                    if ($urandom_range(0, 7) == 0) begin
                        q_req[p]   = 1'b1;
                        q_we[p]    = 1'($urandom);
                        q_byte[p]  = 1'($urandom);
                        q_addr[p]  = 22'($urandom);
                        q_wdata[p] = 16'($urandom);
                    end
                end else if ($urandom_range(0, 199) == 0) begin
                    q_req[p] = 1'b0;
                end
            end
            step();
        end
        rst = 1'b0;
        clear_reqs();
        for (int i = 0; i < 40; i++) step();

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
